// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch stage.
//   NOP_INSTR        - instruction word presented on instr_o while in reset
//   DEFAULT_RESET_PC - default first fetch address
//   if_id_t          - default-width IF/ID bundle for stages that consume it
package fetch_pkg;

  localparam int unsigned FETCH_AW = 32;
  localparam int unsigned FETCH_DW = 32;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [FETCH_DW-1:0] instr;
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_AW-1:0] pc_plus4;
    logic                valid;
  } if_id_t;

endpackage

// File: rtl/pc_next.sv
// pc_next: next-PC selection and the PC register.
//   clk, rst_n     - clock, async active-low reset
//   advance_i      - fetch stage consumes the current PC this cycle
//   redirect_i     - branch/jump taken, redirect_pc_i is the target
//   pc_o           - current fetch address
//   halted_o       - fetch frozen after a misaligned target
//   misalign_o     - sticky misaligned-target flag
// Build option: FETCH_MISALIGN_TRAP_EN enables the misaligned-target trap;
// otherwise target bits [1:0] are dropped and the trap outputs are tied low.
module pc_next
  import fetch_pkg::*;
#(
  parameter int unsigned                ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     advance_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic                     halted_o,
  output logic                     misalign_o
);

  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(4);

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d, tgt;
  logic                     halted_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic mis_q, trap;

  // A misaligned target is still loaded into the PC so the faulting address
  // stays visible on rom_addr_o; the halt then freezes it there.
  assign trap = redirect_i && !halted_q && (redirect_pc_i[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q    <= 1'b0;
      halted_q <= 1'b0;
    end else if (trap) begin
      mis_q    <= 1'b1;
      halted_q <= 1'b1;
    end
  end

  assign tgt        = redirect_pc_i;
  assign misalign_o = mis_q;
`else
  assign halted_q   = 1'b0;
  assign tgt        = {redirect_pc_i[ADDRESS_WIDTH-1:2], 2'b00};
  assign misalign_o = 1'b0;
`endif

  // Redirect wins over sequential advance; a halted unit ignores both.
  always_comb begin
    pc_d = pc_q;
    if (!halted_q) begin
      if (redirect_i)     pc_d = tgt;
      else if (advance_i) pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign pc_o     = pc_q;
  assign halted_o = halted_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: single-issue instruction fetch with an IF/ID output register.
//   clk, rst_n                 - clock, async active-low reset
//   rom_addr_o / rom_data_i    - combinational instruction ROM port
//   redirect_i, redirect_pc_i  - branch/jump taken and its target
//   ready_i                    - decode accepts the IF/ID word
//   valid_o, instr_o, pc_o,
//   pc_plus4_o                 - IF/ID word
//   misalign_o                 - sticky misaligned-target flag
// Build option: FETCH_MISALIGN_TRAP_EN (see pc_next).
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0]    rom_data_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [DATA_WIDTH-1:0]    instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_o,
  output logic                     misalign_o
);

  localparam logic [DATA_WIDTH-1:0]    NOP      = DATA_WIDTH'(NOP_INSTR);
  localparam logic [ADDRESS_WIDTH-1:0] RESET_P4 = RESET_PC + ADDRESS_WIDTH'(4);

  logic [ADDRESS_WIDTH-1:0] pc;
  logic                     halted, stall, advance;

  // A held word blocks the refill; an accepted word is replaced on the same
  // edge, so back-to-back handshakes run without bubbles.
  assign stall   = valid_o && !ready_i;
  assign advance = !stall && !halted;

  pc_next #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .RESET_PC      (RESET_PC)
  ) u_pc_next (
    .clk           (clk),
    .rst_n         (rst_n),
    .advance_i     (advance),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc),
    .halted_o      (halted),
    .misalign_o    (misalign_o)
  );

  assign rom_addr_o = pc;

  // IF/ID register. A redirect kills the word in flight even while stalled;
  // the payload is left as-is since valid_o qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      instr_o    <= NOP;
      pc_o       <= RESET_PC;
      pc_plus4_o <= RESET_P4;
    end else if (redirect_i) begin
      valid_o    <= 1'b0;
    end else if (advance) begin
      valid_o    <= 1'b1;
      instr_o    <= rom_data_i;
      pc_o       <= pc;
      pc_plus4_o <= pc + ADDRESS_WIDTH'(4);
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr, rom_data;
  logic        redirect, ready;
  logic [31:0] redirect_pc;
  logic        valid;
  logic [31:0] instr, pc_o, pc4;
  logic        mis;

  // second instance exercising address wrap from a high reset PC
  logic [31:0] w_rom_addr, w_rom_data, w_instr, w_pc_o, w_pc4;
  logic        w_valid, w_mis;
  logic        one = 1'b1, zero = 1'b0;
  logic [31:0] zero32 = 32'h0;

  int total = 0;
  int bad   = 0;

  // ROM: word at byte address a holds a/4
  assign rom_data   = rom_addr >> 2;
  assign w_rom_data = w_rom_addr >> 2;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .ready_i(ready),
    .valid_o(valid), .instr_o(instr), .pc_o(pc_o), .pc_plus4_o(pc4),
    .misalign_o(mis));

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst_n(rst_n), .rom_addr_o(w_rom_addr), .rom_data_i(w_rom_data),
    .redirect_i(zero), .redirect_pc_i(zero32), .ready_i(one),
    .valid_o(w_valid), .instr_o(w_instr), .pc_o(w_pc_o), .pc_plus4_o(w_pc4),
    .misalign_o(w_mis));

  // reference model state: fetch address plus the word visible to decode
  logic [31:0] m_pc, m_instr, m_pco, m_pc4;
  logic        m_valid, m_mis, m_halt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h13;
    m_pco = 32'h0; m_pc4 = 32'h4; m_mis = 1'b0; m_halt = 1'b0;
  endtask

  // One clock edge of the fetch rules, evaluated on the inputs now applied.
  task automatic model_edge();
    logic [31:0] tgt;
    if (m_halt) return;
    if (redirect) begin
      tgt = redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) begin m_mis = 1'b1; m_halt = 1'b1; end
`else
      tgt = tgt & ~32'h3;
`endif
      m_pc = tgt; m_valid = 1'b0;
    end else if (!(m_valid && !ready)) begin
      m_instr = m_pc / 4; m_pco = m_pc; m_pc4 = m_pc + 32'd4;
      m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(valid), 64'(m_valid));
    chk({tag, ".instr"}, 64'(instr), 64'(m_instr));
    chk({tag, ".pc"},    64'(pc_o),  64'(m_pco));
    chk({tag, ".pc4"},   64'(pc4),   64'(m_pc4));
    chk({tag, ".mis"},   64'(mis),   64'(m_mis));
    chk({tag, ".addr"},  64'(rom_addr), 64'(m_pc));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] wexp;
    rst_n = 1'b0; ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("w_reset.pc",  64'(w_pc_o), 64'(32'hFFFF_FFF8));
    chk("w_reset.pc4", 64'(w_pc4),  64'(32'hFFFF_FFFC));
    rst_n = 1'b1;

    // streaming from reset, wrap instance alongside
    for (int k = 0; k < 3; k++) begin
      step("stream");
      wexp = 32'hFFFF_FFF8 + 32'(4 * k);
      chk("wrap.pc",    64'(w_pc_o), 64'(wexp));
      chk("wrap.valid", 64'(w_valid), 64'd1);
    end
    chk("stream.pc8", 64'(pc_o), 64'h8);

    // stall at pc 8 for three cycles, then release
    ready = 1'b0;
    repeat (3) step("stall");
    chk("stall.addr", 64'(rom_addr), 64'hC);
    ready = 1'b1;
    step("unstall");
    chk("unstall.pc", 64'(pc_o), 64'hC);

    // redirect while stalled
    ready = 1'b0;
    step("stall2");
    redirect = 1'b1; redirect_pc = 32'h40;
    step("redir");
    redirect = 1'b0;
    step("redir_fill");
    chk("redir.pc",    64'(pc_o),  64'h40);
    chk("redir.instr", 64'(instr), 64'd16);
    ready = 1'b1;
    step("redir_run");

    // misaligned target
    redirect = 1'b1; redirect_pc = 32'h42;
    step("mis");
    redirect = 1'b0;
    repeat (3) step("mis_after");

    // async reset pulse between edges
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    rst_n = 1'b1;
    repeat (3) step("restart");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ready       = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      step("rand");
    end
    redirect = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
